// File: rtl/lza_lod_encoder.sv
// Two-stage leading-one detector for the LZA normalisation path: grouped LOD in s1, priority merge in s2.
// Optional one-hot leading-one output enabled by defining LZA_LOD_ONEHOT_EN.
module lza_lod_encoder #(
  parameter int DATA_WIDTH  = 8,
  parameter int GROUP_WIDTH = 4,
  parameter int TAG_WIDTH   = 4,
  parameter int CNT_WIDTH   = $clog2(DATA_WIDTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] string_f,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CNT_WIDTH-1:0]  shift_cnt,
  output logic                  all_zero,
  output logic [TAG_WIDTH-1:0]  out_tag
`ifdef LZA_LOD_ONEHOT_EN
  ,
  output logic [DATA_WIDTH-1:0] lo_onehot
`endif
);

  localparam int NGRP = DATA_WIDTH / GROUP_WIDTH;
  localparam int PW   = (GROUP_WIDTH > 1) ? $clog2(GROUP_WIDTH) : 1;

  logic                     s1_valid, s2_valid;
  logic                     adv1, adv2;
  logic [NGRP-1:0]          grp_any, s1_any;
  logic [NGRP-1:0][PW-1:0]  grp_pos, s1_pos;
  logic [TAG_WIDTH-1:0]     s1_tag;
  logic [CNT_WIDTH-1:0]     nxt_cnt;
  logic                     nxt_zero;

  assign adv2      = !s2_valid || out_ready;
  assign adv1      = !s1_valid || adv2;
  assign in_ready  = adv1;
  assign out_valid = s2_valid;

  // Group g = 0 is the MSB group; pos counts from the group's MSB.
  always_comb begin : group_lod
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    grp_any = '0;
    grp_pos = '0;
    for (int g = 0; g < NGRP; g++) begin
      // Scanning upward from the group LSB lets the last hit be the topmost set bit.
      for (int i = GROUP_WIDTH - 1; i >= 0; i--) begin
        if (string_f[DATA_WIDTH-1-g*GROUP_WIDTH-i]) begin
          grp_any[g] = 1'b1;
          grp_pos[g] = PW'(i);
        end
      end
    end
  end

  always_ff @(posedge clk) begin : stage1
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      s1_valid <= 1'b0;
      s1_any   <= '0;
      s1_pos   <= '0;
      s1_tag   <= '0;
    end else if (adv1) begin
      s1_valid <= in_valid;
      s1_any   <= grp_any;
      s1_pos   <= grp_pos;
      s1_tag   <= in_tag;
    end
  end

  always_comb begin : merge
    nxt_cnt  = CNT_WIDTH'(DATA_WIDTH);
    nxt_zero = 1'b1;
    for (int g = NGRP - 1; g >= 0; g--) begin
      if (s1_any[g]) begin
        nxt_zero = 1'b0;
        nxt_cnt  = CNT_WIDTH'(g * GROUP_WIDTH) + CNT_WIDTH'(s1_pos[g]);
      end
    end
  end

`ifdef LZA_LOD_ONEHOT_EN
  logic [DATA_WIDTH-1:0] nxt_onehot;

  always_comb begin : onehot_dec
    nxt_onehot = '0;
    for (int b = 0; b < DATA_WIDTH; b++) begin
      if (!nxt_zero && nxt_cnt == CNT_WIDTH'(DATA_WIDTH - 1 - b)) nxt_onehot[b] = 1'b1;
    end
  end
`endif

  // Output data only loads with a real entry, so a stalled result stays put.
  always_ff @(posedge clk) begin : stage2
    // NOTE: output data registers are reset too because their reset value is visible on the ports.
    if (rst) begin
      s2_valid  <= 1'b0;
      shift_cnt <= '0;
      all_zero  <= 1'b0;
      out_tag   <= '0;
`ifdef LZA_LOD_ONEHOT_EN
      lo_onehot <= '0;
`endif
    end else if (adv2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        shift_cnt <= nxt_cnt;
        all_zero  <= nxt_zero;
        out_tag   <= s1_tag;
`ifdef LZA_LOD_ONEHOT_EN
        lo_onehot <= nxt_onehot;
`endif
      end
    end
  end

endmodule

// File: tb/tb_lza_lod_encoder.sv
// Self-checking bench for lza_lod_encoder: directed table, stall/reset sequences and a
// randomized stream scored against a bit-scan reference model.
module tb_lza_lod_encoder;

  localparam int DW = 8;
  localparam int GW = 4;
  localparam int TW = 4;
  localparam int CW = $clog2(DW) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] string_f = '0;
  logic [TW-1:0] in_tag = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [CW-1:0] shift_cnt;
  logic          all_zero;
  logic [TW-1:0] out_tag;
`ifdef LZA_LOD_ONEHOT_EN
  logic [DW-1:0] lo_onehot;
`endif

  lza_lod_encoder #(
    .DATA_WIDTH (DW),
    .GROUP_WIDTH(GW),
    .TAG_WIDTH  (TW),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .string_f (string_f),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .shift_cnt(shift_cnt),
    .all_zero (all_zero),
    .out_tag  (out_tag)
`ifdef LZA_LOD_ONEHOT_EN
    ,
    .lo_onehot(lo_onehot)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: count zeros from the MSB down to the first one.
  function automatic logic [CW-1:0] ref_lzc(input logic [DW-1:0] f);
    for (int i = DW - 1; i >= 0; i--) if (f[i]) return CW'(DW - 1 - i);
    return CW'(DW);
  endfunction

  function automatic logic [DW-1:0] ref_onehot(input logic [DW-1:0] f);
    logic [DW-1:0] r;
    r = '0;
    for (int i = DW - 1; i >= 0; i--) if (f[i]) begin r[i] = 1'b1; return r; end
    return r;
  endfunction

  typedef struct {
    logic [CW-1:0] cnt;
    logic          az;
    logic [TW-1:0] tag;
    logic [DW-1:0] oh;
  } exp_t;

  exp_t exp_q[$];
  int   n_pop = 0;

  // Scoreboard: handshakes sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_pop++;
        if (exp_q.size() == 0) begin
          check("sb_unexpected_output", {out_tag, shift_cnt}, '1);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("sb_result", {shift_cnt, all_zero, out_tag}, {e.cnt, e.az, e.tag});
`ifdef LZA_LOD_ONEHOT_EN
          check("sb_onehot", lo_onehot, e.oh);
`endif
        end
      end
      if (in_valid && in_ready) begin
        exp_t e;
        e.cnt = ref_lzc(string_f);
        e.az  = (string_f == '0);
        e.tag = in_tag;
        e.oh  = ref_onehot(string_f);
        exp_q.push_back(e);
      end
    end
  end

  typedef struct {
    logic [DW-1:0] f;
    logic [TW-1:0] tag;
    logic [CW-1:0] cnt;
    logic          az;
    logic [DW-1:0] oh;
  } vec_t;

  vec_t tbl[6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_single(input vec_t v, input string name);
    check({name, "_in_ready"}, in_ready, 1'b1);
    in_valid = 1'b1;
    string_f = v.f;
    in_tag   = v.tag;
    step();
    in_valid = 1'b0;
    check({name, "_lat1_valid"}, out_valid, 1'b0);
    step();
    check({name, "_lat2_valid"}, out_valid, 1'b1);
    check({name, "_result"}, {shift_cnt, all_zero, out_tag}, {v.cnt, v.az, v.tag});
`ifdef LZA_LOD_ONEHOT_EN
    check({name, "_onehot"}, lo_onehot, v.oh);
`endif
    step();
  endtask

  initial begin
    tbl[0] = '{8'b0001_0110, 4'd3, 4'd3, 1'b0, 8'h10};
    tbl[1] = '{8'h80,        4'd1, 4'd0, 1'b0, 8'h80};
    tbl[2] = '{8'h01,        4'd2, 4'd7, 1'b0, 8'h01};
    tbl[3] = '{8'h00,        4'd4, 4'd8, 1'b1, 8'h00};
    tbl[4] = '{8'h0F,        4'd5, 4'd4, 1'b0, 8'h08};
    tbl[5] = '{8'h3C,        4'd9, 4'd2, 1'b0, 8'h20};

    // Reset state
    rst = 1'b1;
    step();
    step();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_outputs", {shift_cnt, all_zero, out_tag}, '0);
    check("rst_in_ready", in_ready, 1'b1);
`ifdef LZA_LOD_ONEHOT_EN
    check("rst_onehot", lo_onehot, '0);
`endif
    rst = 1'b0;
    step();

    // Directed table
    for (int i = 0; i < 6; i++) apply_single(tbl[i], $sformatf("tbl%0d", i));

    // Back-to-back stream of walking ones
    for (int j = 0; j < 10; j++) begin
      if (j < 8) begin
        in_valid = 1'b1;
        string_f = DW'(1) << (7 - j);
        in_tag   = TW'(j);
      end else begin
        in_valid = 1'b0;
      end
      step();
      if (j == 0 || j == 9) begin
        check($sformatf("stream_idle_%0d", j), out_valid, 1'b0);
      end else begin
        check($sformatf("stream_out_%0d", j - 1), {out_valid, shift_cnt, out_tag},
              {1'b1, CW'(j - 1), TW'(j - 1)});
      end
    end

    // Stall with both stages full
    out_ready = 1'b0;
    in_valid  = 1'b1;
    string_f  = 8'h20;
    in_tag    = 4'd1;
    step();
    string_f = 8'h04;
    in_tag   = 4'd2;
    step();
    string_f = 8'h00;
    in_tag   = 4'd3;
    check("stall_in_ready", in_ready, 1'b0);
    check("stall_first", {out_valid, shift_cnt, out_tag}, {1'b1, 4'd2, 4'd1});
    for (int k = 0; k < 2; k++) begin
      step();
      check($sformatf("stall_hold_%0d", k), {in_ready, out_valid, shift_cnt, all_zero, out_tag},
            {1'b0, 1'b1, 4'd2, 1'b0, 4'd1});
    end
    out_ready = 1'b1;
    #1;
    check("release_in_ready", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    check("release_b", {out_valid, shift_cnt, all_zero, out_tag}, {1'b1, 4'd5, 1'b0, 4'd2});
    step();
    check("release_c", {out_valid, shift_cnt, all_zero, out_tag}, {1'b1, 4'd8, 1'b1, 4'd3});
    step();
    check("release_drained", out_valid, 1'b0);

    // Reset with two entries in flight
    in_valid = 1'b1;
    string_f = 8'h40;
    in_tag   = 4'd6;
    step();
    string_f = 8'h02;
    in_tag   = 4'd7;
    step();
    in_valid = 1'b0;
    rst      = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_outputs", {out_valid, shift_cnt, all_zero, out_tag}, '0);
    begin
      int seen;
      seen = 0;
      for (int k = 0; k < 4; k++) begin
        step();
        if (out_valid) seen++;
      end
      check("midrst_no_ghost", seen, 0);
    end
    apply_single(tbl[0], "post_rst");

    // Randomized stream
    begin
      int start, cycles;
      logic [DW-1:0] r;
      start  = n_pop;
      cycles = 0;
      while (n_pop - start < 1000 && cycles < 20000) begin
        r = DW'($urandom) >> $urandom_range(0, DW);
        if ($urandom_range(0, 7) == 0) r = '0;
        in_valid  = ($urandom_range(0, 9) < 7);
        string_f  = r;
        in_tag    = TW'($urandom);
        out_ready = ($urandom_range(0, 9) < 7);
        step();
        cycles++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) step();
      check("rand_transfers_done", (n_pop - start >= 1000), 1'b1);
      check("rand_queue_empty", exp_q.size(), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
